// File: rtl/bus_mmio.sv
// MMIO bridge: takes one single-beat command from the main bus, decodes a
// 256-byte peripheral slot and runs a psel/pready access with a per-access timeout.
module bus_mmio #(
    parameter int N_SLOTS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_core,
    input  logic                   reset,
    input  logic                   bmain_cvalid_bmmio,
    output logic                   bmmio_cready,
    input  logic                   bmain_cmd,
    input  logic [9:0]             bmain_addr,
    input  logic                   bmain_wvalid_bmmio,
    output logic                   bmmio_wready,
    input  logic                   bmain_wlast,
    input  logic [31:0]            bmain_wdata,
    input  logic [3:0]             bmain_wmask,
    output logic                   bmmio_rvalid,
    input  logic                   bmain_rready_bmmio,
    output logic [31:0]            bmmio_rdata,
    output logic                   bmmio_error,
    input  logic                   bmain_eack_bmmio,
    output logic [N_SLOTS-1:0]     bmmio_psel,
    output logic                   bmmio_pwrite,
    output logic [5:0]             bmmio_paddr,
    output logic [31:0]            bmmio_pwdata,
    output logic [3:0]             bmmio_pmask,
    input  logic [N_SLOTS-1:0]     periph_pready,
    input  logic [32*N_SLOTS-1:0]  periph_prdata,
    input  logic [N_SLOTS-1:0]     periph_perr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_cmd_rd;
    logic [3:0]  r_slot;
    logic        r_mapped;
    logic [5:0]  r_paddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        r_burst;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;

    logic [3:0]  w_cmd_slot;
    logic        w_cmd_mapped;
    logic        w_sel_pready;
    logic        w_sel_perr;
    logic [31:0] w_sel_prdata;
    logic        w_timeout;

    assign w_cmd_slot   = bmain_addr[9:6];
    assign w_cmd_mapped = ({1'b0, w_cmd_slot} < 5'(N_SLOTS));
    assign w_timeout    = (r_cnt == 8'(TIMEOUT - 1));

    // Only the latched slot's handshake and data are looked at.
    always_comb begin
        w_sel_pready = 1'b0;
        w_sel_perr   = 1'b0;
        w_sel_prdata = '0;
        for (int unsigned n = 0; n < N_SLOTS; n++) begin
            if (r_slot == 4'(n)) begin
                w_sel_pready = periph_pready[n];
                w_sel_perr   = periph_perr[n];
                w_sel_prdata = periph_prdata[32*n +: 32];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bmain_cvalid_bmmio) begin
                    if (!bmain_cmd)        w_next = S_WDATA;
                    else if (w_cmd_mapped) w_next = S_ACCESS;
                    else                   w_next = S_ERR;
                end
            end
            S_WDATA: begin
                if (bmain_wvalid_bmmio && bmain_wlast) begin
                    if (r_burst)                 w_next = S_ERR;
                    else if (bmain_wmask == '0)  w_next = S_IDLE;
                    else if (!r_mapped)          w_next = S_ERR;
                    else                         w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // pready wins over a timeout landing on the same edge
                if (w_sel_pready) begin
                    if (w_sel_perr)    w_next = S_ERR;
                    else if (r_cmd_rd) w_next = S_RESP;
                    else               w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_RESP: begin
                if (bmain_rready_bmmio) w_next = S_IDLE;
            end
            S_ERR: begin
                if (bmain_eack_bmmio) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_cmd_rd <= 1'b0;
            r_slot   <= '0;
            r_mapped <= 1'b0;
            r_paddr  <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_burst  <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= '0;
        end else begin
            if (r_state == S_IDLE && bmain_cvalid_bmmio) begin
                r_cmd_rd <= bmain_cmd;
                r_slot   <= w_cmd_slot;
                r_mapped <= w_cmd_mapped;
                r_paddr  <= bmain_addr[5:0];
                r_burst  <= 1'b0;
            end
            // r_burst marks that a non-final beat was seen; later beats are dropped
            if (r_state == S_WDATA && bmain_wvalid_bmmio) begin
                if (!r_burst) begin
                    r_wdata <= bmain_wdata;
                    r_wmask <= bmain_wmask;
                end
                if (!bmain_wlast) r_burst <= 1'b1;
            end
            if (r_state == S_ACCESS) r_cnt <= r_cnt + 8'd1;
            else                     r_cnt <= '0;
            if (r_state == S_ACCESS && w_sel_pready && !w_sel_perr && r_cmd_rd)
                r_rdata <= w_sel_prdata;
        end
    end

    always_comb begin
        bmmio_psel = '0;
        for (int unsigned n = 0; n < N_SLOTS; n++) begin
            bmmio_psel[n] = (r_state == S_ACCESS) && (r_slot == 4'(n));
        end
    end

    assign bmmio_cready = (r_state == S_IDLE);
    assign bmmio_wready = (r_state == S_WDATA);
    assign bmmio_rvalid = (r_state == S_RESP);
    assign bmmio_error  = (r_state == S_ERR);
    assign bmmio_rdata  = r_rdata;
    assign bmmio_pwrite = !r_cmd_rd;
    assign bmmio_paddr  = r_paddr;
    assign bmmio_pwdata = r_wdata;
    assign bmmio_pmask  = r_cmd_rd ? 4'hf : r_wmask;

endmodule

// File: tb/tb_bus_mmio.sv
// Scoreboard bench for bus_mmio: a transaction-level model predicts each access
// and response; an independent monitor checks what the bridge actually presents.
module tb_bus_mmio;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam int K_NONE = 0;
    localparam int K_WOK  = 1;
    localparam int K_ROK  = 2;
    localparam int K_ERR  = 3;

    logic            clk_core = 1'b0;
    logic            reset;
    logic            bmain_cvalid_bmmio;
    logic            bmmio_cready;
    logic            bmain_cmd;
    logic [9:0]      bmain_addr;
    logic            bmain_wvalid_bmmio;
    logic            bmmio_wready;
    logic            bmain_wlast;
    logic [31:0]     bmain_wdata;
    logic [3:0]      bmain_wmask;
    logic            bmmio_rvalid;
    logic            bmain_rready_bmmio;
    logic [31:0]     bmmio_rdata;
    logic            bmmio_error;
    logic            bmain_eack_bmmio;
    logic [NS-1:0]   bmmio_psel;
    logic            bmmio_pwrite;
    logic [5:0]      bmmio_paddr;
    logic [31:0]     bmmio_pwdata;
    logic [3:0]      bmmio_pmask;
    logic [NS-1:0]   periph_pready;
    logic [32*NS-1:0] periph_prdata;
    logic [NS-1:0]   periph_perr;

    always #5 clk_core = ~clk_core;

    bus_mmio #(.N_SLOTS(NS), .TIMEOUT(TO)) dut (
        .clk_core(clk_core), .reset(reset),
        .bmain_cvalid_bmmio(bmain_cvalid_bmmio), .bmmio_cready(bmmio_cready),
        .bmain_cmd(bmain_cmd), .bmain_addr(bmain_addr),
        .bmain_wvalid_bmmio(bmain_wvalid_bmmio), .bmmio_wready(bmmio_wready),
        .bmain_wlast(bmain_wlast), .bmain_wdata(bmain_wdata), .bmain_wmask(bmain_wmask),
        .bmmio_rvalid(bmmio_rvalid), .bmain_rready_bmmio(bmain_rready_bmmio),
        .bmmio_rdata(bmmio_rdata), .bmmio_error(bmmio_error),
        .bmain_eack_bmmio(bmain_eack_bmmio), .bmmio_psel(bmmio_psel),
        .bmmio_pwrite(bmmio_pwrite), .bmmio_paddr(bmmio_paddr),
        .bmmio_pwdata(bmmio_pwdata), .bmmio_pmask(bmmio_pmask),
        .periph_pready(periph_pready), .periph_prdata(periph_prdata),
        .periph_perr(periph_perr)
    );

    typedef struct {
        logic [NS-1:0] psel;
        logic          pwrite;
        logic [5:0]    paddr;
        logic [31:0]   pwdata;
        logic [3:0]    pmask;
        int            ncyc;
    } acc_t;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } rsp_t;

    acc_t q_acc[$];
    rsp_t q_rsp[$];

    int n_checks = 0;
    int n_fail   = 0;

    int          cfg_slot = 0;
    int          cfg_lat  = 0;
    bit          cfg_perr = 1'b0;
    logic [31:0] cfg_data = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Peripheral: the configured slot answers cfg_lat cycles into the access; all
    // other handshake/data lines carry random noise the bridge must ignore.
    initial begin
        int k;
        logic [NS-1:0]    pr;
        logic [NS-1:0]    pe;
        logic [32*NS-1:0] pd;
        k = 0;
        periph_pready = '0;
        periph_perr   = '0;
        periph_prdata = '0;
        forever begin
            @(negedge clk_core);
            pr = NS'($urandom);
            pe = NS'($urandom);
            for (int n = 0; n < NS; n++) pd[32*n +: 32] = $urandom;
            if (bmmio_psel != '0) begin
                pr[cfg_slot] = (k == cfg_lat);
                if (k == cfg_lat) begin
                    pe[cfg_slot] = cfg_perr;
                    pd[32*cfg_slot +: 32] = cfg_data;
                end
                k++;
            end else begin
                k = 0;
            end
            periph_pready = pr;
            periph_perr   = pe;
            periph_prdata = pd;
        end
    end

    // Monitor: pops predicted accesses/responses as the DUT presents them.
    initial begin
        acc_t        cur;
        rsp_t        r;
        bit          in_acc, prev_rv, prev_err, just_fell;
        int          cyc;
        logic [31:0] exp_rd;
        in_acc = 0; prev_rv = 0; prev_err = 0; cyc = 0; exp_rd = '0;
        cur = '{psel: '0, pwrite: 1'b0, paddr: '0, pwdata: '0, pmask: '0, ncyc: -1};
        forever begin
            @(negedge clk_core);
            just_fell = 0;
            if (reset) begin
                in_acc = 0; prev_rv = 0; prev_err = 0;
                continue;
            end
            chk("one_state", $countones({bmmio_cready, bmmio_wready, bmmio_rvalid,
                                         bmmio_error, |bmmio_psel}), 1);
            if (bmmio_psel != '0) begin
                if (!in_acc) begin
                    in_acc = 1; cyc = 1;
                    if (q_acc.size() == 0) begin
                        chk("psel_unexpected", 32'(bmmio_psel), 0);
                        cur = '{psel: bmmio_psel, pwrite: bmmio_pwrite, paddr: bmmio_paddr,
                                pwdata: bmmio_pwdata, pmask: bmmio_pmask, ncyc: -1};
                    end else begin
                        cur = q_acc.pop_front();
                        chk("psel", 32'(bmmio_psel), 32'(cur.psel));
                        chk("pwrite", 32'(bmmio_pwrite), 32'(cur.pwrite));
                        chk("paddr", 32'(bmmio_paddr), 32'(cur.paddr));
                        chk("pmask", 32'(bmmio_pmask), 32'(cur.pmask));
                        if (cur.pwrite) chk("pwdata", bmmio_pwdata, cur.pwdata);
                    end
                end else begin
                    cyc++;
                    chk("psel_stable", {17'd0, bmmio_pwrite, bmmio_paddr, bmmio_pmask, bmmio_psel},
                        {17'd0, cur.pwrite, cur.paddr, cur.pmask, cur.psel});
                end
            end else if (in_acc) begin
                in_acc = 0; just_fell = 1;
                if (cur.ncyc >= 0) chk("psel_cycles", cyc, cur.ncyc);
            end
            if (bmmio_rvalid && !prev_rv) begin
                if (q_rsp.size() == 0) begin
                    chk("rvalid_unexpected", 32'(bmmio_rvalid), 0);
                end else begin
                    r = q_rsp.pop_front();
                    exp_rd = r.data;
                    chk("resp_is_read", 32'(r.is_err), 0);
                    chk("rdata", bmmio_rdata, r.data);
                    chk("rvalid_lat", 32'(just_fell), 1);
                end
            end else if (bmmio_rvalid && prev_rv) begin
                chk("rdata_stable", bmmio_rdata, exp_rd);
            end
            if (bmmio_error && !prev_err) begin
                if (q_rsp.size() == 0) begin
                    chk("error_unexpected", 32'(bmmio_error), 0);
                end else begin
                    r = q_rsp.pop_front();
                    chk("resp_is_error", 32'(r.is_err), 1);
                end
            end
            prev_rv  = bmmio_rvalid;
            prev_err = bmmio_error;
        end
    end

    task automatic recover();
        reset = 1'b1;
        repeat (2) @(negedge clk_core);
        reset = 1'b0;
        q_acc.delete();
        q_rsp.delete();
        @(negedge clk_core);
    endtask

    // One transaction: predict, issue, then service rvalid/error until cready returns.
    task automatic run_txn(input bit rd, input logic [9:0] addr, input int nbeats,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input int lat, input bit perr, input logic [31:0] rdat,
                           input int rdly, input int edly);
        int   slot, kind, ncyc, cyc, rcnt, ecyc;
        bit   mapped, access;
        acc_t a;
        rsp_t r;
        slot   = int'(addr[9:6]);
        mapped = (slot < NS);
        access = 0; ncyc = 0; kind = K_NONE;
        if (rd) begin
            if (!mapped) kind = K_ERR;
            else         access = 1;
        end else if (nbeats > 1) kind = K_ERR;
        else if (wmask == 4'h0)  kind = K_NONE;
        else if (!mapped)        kind = K_ERR;
        else                     access = 1;
        if (access) begin
            if (lat < TO) begin
                ncyc = lat + 1;
                kind = perr ? K_ERR : (rd ? K_ROK : K_WOK);
            end else begin
                ncyc = TO;
                kind = K_ERR;
            end
            a.psel   = NS'(1 << slot);
            a.pwrite = !rd;
            a.paddr  = addr[5:0];
            a.pwdata = wdata;
            a.pmask  = rd ? 4'hf : wmask;
            a.ncyc   = ncyc;
            q_acc.push_back(a);
        end
        if (kind == K_ROK || kind == K_ERR) begin
            r.is_err = (kind == K_ERR);
            r.data   = rdat;
            q_rsp.push_back(r);
        end
        cfg_slot = slot; cfg_lat = lat; cfg_perr = perr; cfg_data = rdat;

        bmain_cvalid_bmmio = 1'b1;
        bmain_cmd  = rd;
        bmain_addr = addr;
        @(negedge clk_core);
        bmain_cvalid_bmmio = 1'b0;
        if (!rd) begin
            for (int b = 0; b < nbeats; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bmain_wvalid_bmmio = 1'b0;
                    @(negedge clk_core);
                end
                chk("wready", 32'(bmmio_wready), 1);
                bmain_wvalid_bmmio = 1'b1;
                bmain_wlast = (b == nbeats - 1);
                bmain_wdata = (b == 0) ? wdata : $urandom;
                bmain_wmask = (b == 0) ? wmask : 4'($urandom);
                @(negedge clk_core);
            end
            bmain_wvalid_bmmio = 1'b0;
            bmain_wlast = 1'b0;
        end
        if (access) chk("psel_lat", 32'(bmmio_psel != '0), 1);

        cyc = 0; rcnt = 0; ecyc = 0;
        while (!bmmio_cready && cyc < 80) begin
            bmain_cvalid_bmmio = 1'($urandom);
            bmain_wvalid_bmmio = 1'($urandom);
            if (bmmio_rvalid) begin
                bmain_rready_bmmio = (rcnt == rdly);
                rcnt++;
            end else bmain_rready_bmmio = 1'($urandom);
            if (bmmio_error) begin
                ecyc++;
                bmain_eack_bmmio = (ecyc > edly);
            end else bmain_eack_bmmio = 1'($urandom);
            @(negedge clk_core);
            cyc++;
        end
        bmain_cvalid_bmmio = 1'b0;
        bmain_wvalid_bmmio = 1'b0;
        bmain_rready_bmmio = 1'b0;
        bmain_eack_bmmio   = 1'b0;
        if (!bmmio_cready) begin
            chk("done_timeout", 32'(bmmio_cready), 1);
            recover();
        end else begin
            if (kind == K_NONE) chk("wmask0_cready", cyc, 0);
            if (kind == K_ERR)  chk("err_hold", ecyc, edly + 1);
            if (kind == K_ROK)  chk("rvalid_hold", rcnt, rdly + 1);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk_core);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        acc_t a;
        int   slot;
        reset = 1'b1;
        bmain_cvalid_bmmio = 1'b0; bmain_cmd = 1'b0; bmain_addr = '0;
        bmain_wvalid_bmmio = 1'b0; bmain_wlast = 1'b0; bmain_wdata = '0; bmain_wmask = '0;
        bmain_rready_bmmio = 1'b0; bmain_eack_bmmio = 1'b0;
        repeat (3) @(negedge clk_core);
        chk("rst_cready", 32'(bmmio_cready), 1);
        chk("rst_wready", 32'(bmmio_wready), 0);
        chk("rst_rvalid", 32'(bmmio_rvalid), 0);
        chk("rst_error",  32'(bmmio_error), 0);
        chk("rst_psel",   32'(bmmio_psel), 0);
        reset = 1'b0;
        @(negedge clk_core);

        run_txn(1, 10'h041, 1, 32'h0, 4'h0, 0, 0, 32'hdeadbeef, 0, 0);
        run_txn(0, 10'h002, 1, 32'h12345678, 4'b0011, 3, 0, 32'h0, 0, 0);
        run_txn(1, 10'h3c0, 1, 32'h0, 4'h0, 0, 0, 32'h0, 0, 4);
        run_txn(1, 10'h080, 1, 32'h0, 4'h0, 100, 0, 32'h0, 0, 2);
        run_txn(1, 10'h085, 1, 32'h0, 4'h0, TO - 1, 0, 32'hcafef00d, 1, 0);
        run_txn(1, 10'h0c3, 1, 32'h0, 4'h0, 2, 1, 32'h55aa55aa, 0, 1);
        run_txn(0, 10'h010, 3, 32'hfeedface, 4'hf, 0, 0, 32'h0, 0, 1);
        run_txn(0, 10'h010, 1, 32'h0badf00d, 4'h0, 0, 0, 32'h0, 0, 0);
        run_txn(0, 10'h3ff, 1, 32'h11112222, 4'h5, 0, 0, 32'h0, 0, 0);

        // Reset in the middle of a hung read; the access is abandoned.
        cfg_slot = 2; cfg_lat = 100; cfg_perr = 0; cfg_data = 32'h0;
        a = '{psel: 4'b0100, pwrite: 1'b0, paddr: 6'h07, pwdata: '0, pmask: 4'hf, ncyc: -1};
        q_acc.push_back(a);
        bmain_cvalid_bmmio = 1'b1; bmain_cmd = 1'b1; bmain_addr = 10'h087;
        @(negedge clk_core);
        bmain_cvalid_bmmio = 1'b0;
        chk("rst_mid_psel_on", 32'(bmmio_psel), 32'h4);
        repeat (2) @(negedge clk_core);
        reset = 1'b1;
        @(negedge clk_core);
        chk("rst_mid_psel",   32'(bmmio_psel), 0);
        chk("rst_mid_rvalid", 32'(bmmio_rvalid), 0);
        chk("rst_mid_error",  32'(bmmio_error), 0);
        chk("rst_mid_cready", 32'(bmmio_cready), 1);
        reset = 1'b0;
        @(negedge clk_core);
        run_txn(1, 10'h09a, 1, 32'h0, 4'h0, 1, 0, 32'h600dcafe, 0, 0);

        for (int i = 0; i < 300; i++) begin
            bit rd;
            int nb, lat;
            rd   = 1'($urandom_range(0, 1));
            slot = ($urandom_range(0, 5) == 0) ? int'($urandom_range(NS, 15))
                                               : int'($urandom_range(0, NS - 1));
            nb   = (!rd && $urandom_range(0, 6) == 0) ? int'($urandom_range(2, 4)) : 1;
            lat  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                               : int'($urandom_range(0, 4));
            run_txn(rd, {4'(slot), 6'($urandom)}, nb, $urandom,
                    ($urandom_range(0, 6) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    lat, ($urandom_range(0, 7) == 0), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk_core);
        chk("acc_queue_empty", q_acc.size(), 0);
        chk("rsp_queue_empty", q_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mmio.md
Name: bus_mmio

Overview:
Bridge between the main bus mmio slave port and the on-chip peripherals in the 0x02000000-0x02000fff window. It accepts one single-beat command at a time, decodes a 256-byte peripheral slot, and runs a psel/pready access on that slot. It returns read data or signals an access fault. A per-access timeout guarantees that a hung peripheral cannot stall the bus.

Parameters:
N_SLOTS, 4, number of peripheral slots (1..16); slot n decodes addr[11:8]==n
TIMEOUT, 255, max cycles psel may wait for pready before faulting (1..255)

Ports:
clk_core  in  1  core clock
reset  in  1  synchronous active-high reset
bmain_cvalid_bmmio  in  1  command valid
bmmio_cready  out  1  command ready
bmain_cmd  in  1  1=read, 0=write
bmain_addr  in  10  word address [11:2] within the mmio window
bmain_wvalid_bmmio  in  1  write data valid
bmmio_wready  out  1  write data ready
bmain_wlast  in  1  last write beat
bmain_wdata  in  32  write data
bmain_wmask  in  4  byte enables
bmmio_rvalid  out  1  read data valid (always a single beat)
bmain_rready_bmmio  in  1  read data ready
bmmio_rdata  out  32  read data
bmmio_error  out  1  access fault, held until acked
bmain_eack_bmmio  in  1  error acknowledge
bmmio_psel  out  N_SLOTS  one-hot peripheral select
bmmio_pwrite  out  1  1=write access
bmmio_paddr  out  6  word offset within slot (addr[7:2])
bmmio_pwdata  out  32  write data
bmmio_pmask  out  4  byte enables; 4'hf on reads
periph_pready  in  N_SLOTS  per-slot access complete
periph_prdata  in  32*N_SLOTS  per-slot read data; slot n at [32n+31:32n]
periph_perr  in  N_SLOTS  per-slot error, sampled with pready

Behaviour:
- FSM states: IDLE, WDATA, ACCESS, RESP, ERR. On reset, state=IDLE, psel=0, rvalid=0, error=0, timeout counter=0. Reset mid-access drops psel on the next edge, with no completion.
- IDLE: cready=1. A command beat latches cmd, addr, and a slot decode. A write goes to WDATA. A read with a mapped slot goes to ACCESS. A read with an unmapped slot (addr[11:8]>=N_SLOTS) goes to ERR.
- WDATA: wready=1. The first wdata beat latches wdata and wmask.
  - If wlast=1 and the slot is mapped and wmask!=0, go to ACCESS.
  - If wlast=1 and wmask==0, go to IDLE with no peripheral access.
  - If wlast=1 and the slot is unmapped, go to ERR.
  - If wlast=0 (burst), stay in WDATA and accept-and-discard beats until wlast, then go to ERR with no access.
- ACCESS: psel[slot]=1 with stable pwrite/paddr/pwdata/pmask. Entry is one cycle after the latching beat. The counter increments each cycle psel is held.
  - pready[slot]=1 with perr=0: a read registers prdata and goes to RESP; a write goes to IDLE.
  - pready[slot]=1 with perr=1: go to ERR.
  - Counter reaches TIMEOUT without pready: go to ERR.
  - psel deasserts on the edge where the state leaves ACCESS. The counter clears on entry.
- RESP: rvalid=1, rdata stable. A beat (rvalid&rready) goes to IDLE.
- ERR: error=1 until an eack cycle, then go to IDLE. rvalid is never asserted for a faulted read.
- Only one command is outstanding. cready=0 outside IDLE, wready=0 outside WDATA, and rvalid is asserted only in RESP.
- Minimum latencies:
  - Read: cmd beat at cycle 0, psel at cycle 1, pready at cycle 1, rvalid at cycle 2, next cready at cycle 3.
  - Write: cmd at 0, wdata at 1, psel at 2.
- Inputs other than the selected slot's pready/perr/prdata are ignored. A pready arriving on the same edge as the timeout counts as success.

Test Plan:
- Read at 0x104, slot 1 pready at the first psel cycle with prdata=0xdeadbeef -> psel=4'b0010, paddr=1, pmask=4'hf; rvalid at cycle 2 with rdata=0xdeadbeef; cready back after the rready beat.
- Write at 0x008, wdata=0x12345678, wmask=4'b0011, slot 0 pready after 3 cycles -> psel=4'b0001 for 4 cycles, pwrite=1, pwdata/pmask as sent; cready=0 until completion.
- Read at 0xf00 with N_SLOTS=4 -> no psel; error=1 held 5 cycles until eack; rvalid never asserted.
- Read slot 2 with pready held low, TIMEOUT=8 -> psel high exactly 8 cycles, then error=1.
- 3-beat write burst (wlast on beat 3) -> all 3 beats accepted, no psel, then error; 1-beat write with wmask=0 -> no psel, cready=1 next cycle.
- Reset asserted during ACCESS with rready low -> psel=0, rvalid=0, error=0, cready=1 after the reset edge; a following read completes normally.
